// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the video pipeline.
// Default 800x600 timing, derived totals, active-window origin, coordinate widths.
package vga_pkg;

  localparam int COL_W = 11;
  localparam int FIL_W = 10;

  localparam int H_VIS_D  = 800;
  localparam int H_FP_D   = 40;
  localparam int H_SYNC_D = 128;
  localparam int H_BP_D   = 88;

  localparam int V_VIS_D  = 600;
  localparam int V_FP_D   = 1;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D   = 33;

  localparam int H_TOTAL =
    H_VIS_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL =
    V_VIS_D + V_FP_D + V_SYNC_D + V_BP_D;

  // First visible column/row; addressing stages subtract these.
  localparam int H_ACT_INI = H_SYNC_D + H_BP_D;
  localparam int V_ACT_INI = V_SYNC_D + V_BP_D;

endpackage

// File: rtl/contador_mod.sv
// Wrap-around counter with enable and terminal-count flag.
// Ports: clk, rst, en, q (registered), q_nxt (next value), tc (q == LAST).
module contador_mod #(
  parameter int W    = 11,
  parameter int LAST = 1055
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q,
  output logic [W-1:0] q_nxt,
  output logic         tc
);

  localparam logic [W-1:0] LAST_L = W'(LAST);

  assign tc = (q == LAST_L);

  always_comb begin
    q_nxt = q;
    if (en) begin
      q_nxt = tc ? '0 : q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/sincronismo_vga.sv
// VGA timing generator: column/row counters plus registered sync decode.
// Ports: clk, rst, pix_ce in; Columnas, Filas, hsync, vsync, video_on, fin_cuadro out.
module sincronismo_vga
  import vga_pkg::*;
#(
  parameter int H_VIS    = H_VIS_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_VIS    = V_VIS_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  output logic [COL_W-1:0] Columnas,
  output logic [FIL_W-1:0] Filas,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             fin_cuadro
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_INI = H_SYNC + H_BP;
  localparam int V_INI = V_SYNC + V_BP;
  localparam int H_FIN = H_INI + H_VIS;
  localparam int V_FIN = V_INI + V_VIS;

  logic [COL_W-1:0] h_nxt;
  logic [FIL_W-1:0] v_nxt;
  logic             h_tc;
  logic             v_tc;
  logic             h_vis;
  logic             v_vis;

  contador_mod #(
    .W    (COL_W),
    .LAST (H_TOT - 1)
  ) u_hor (
    .clk   (clk),
    .rst   (rst),
    .en    (pix_ce),
    .q     (Columnas),
    .q_nxt (h_nxt),
    .tc    (h_tc)
  );

  contador_mod #(
    .W    (FIL_W),
    .LAST (V_TOT - 1)
  ) u_ver (
    .clk   (clk),
    .rst   (rst),
    .en    (pix_ce & h_tc),
    .q     (Filas),
    .q_nxt (v_nxt),
    .tc    (v_tc)
  );

  // Decode the next counts so the flags line up with the counters.
  assign h_vis = (int'(h_nxt) >= H_INI) &&
                 (int'(h_nxt) <  H_FIN);
  assign v_vis = (int'(v_nxt) >= V_INI) &&
                 (int'(v_nxt) <  V_FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync      <= SYNC_POL;
      vsync      <= SYNC_POL;
      video_on   <= 1'b0;
      fin_cuadro <= 1'b0;
    end else begin
      hsync      <= (int'(h_nxt) < H_SYNC) ?
                    SYNC_POL : ~SYNC_POL;
      vsync      <= (int'(v_nxt) < V_SYNC) ?
                    SYNC_POL : ~SYNC_POL;
      video_on   <= h_vis & v_vis;
      fin_cuadro <= pix_ce & h_tc & v_tc;
    end
  end

endmodule

// File: tb/tb_sincronismo_vga.sv
// Directed bench for sincronismo_vga: default, inverted-polarity
// and reduced-size instances against hand-computed values.
module tb_sincronismo_vga;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce_d = 1'b0;
  logic ce_r = 1'b0;

  always #5 clk = ~clk;

  logic [10:0] col_d, col_p, col_r;
  logic [9:0]  fil_d, fil_p, fil_r;
  logic hs_d, vs_d, vid_d, fin_d;
  logic hs_p, vs_p, vid_p, fin_p;
  logic hs_r, vs_r, vid_r, fin_r;

  sincronismo_vga u_dut (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (ce_d),
    .Columnas   (col_d),
    .Filas      (fil_d),
    .hsync      (hs_d),
    .vsync      (vs_d),
    .video_on   (vid_d),
    .fin_cuadro (fin_d)
  );

  sincronismo_vga #(
    .SYNC_POL (1'b1)
  ) u_pol (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (ce_d),
    .Columnas   (col_p),
    .Filas      (fil_p),
    .hsync      (hs_p),
    .vsync      (vs_p),
    .video_on   (vid_p),
    .fin_cuadro (fin_p)
  );

  sincronismo_vga #(
    .H_VIS (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_VIS (3), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) u_red (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (ce_r),
    .Columnas   (col_r),
    .Filas      (fil_r),
    .hsync      (hs_r),
    .vsync      (vs_r),
    .video_on   (vid_r),
    .fin_cuadro (fin_r)
  );

  int n_chk = 0;
  int n_err = 0;
  int pos   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Pulse pix_ce on the default instances until pos reaches tgt.
  task automatic run_to(input int tgt);
    ce_d = 1'b1;
    while (pos < tgt) begin
      @(negedge clk);
      pos++;
    end
    ce_d = 1'b0;
  endtask

  // Reduced-instance reference state.
  int mc = 0;
  int mr = 0;
  int fin_cnt = 0;
  int fin_exp = 0;

  task automatic red_step(input logic v);
    logic ef;
    ce_r = v;
    @(negedge clk);
    ef = 1'b0;
    if (v) begin
      ef = (mc == 7) && (mr == 5);
      if (mc == 7) begin
        mc = 0;
        mr = (mr == 5) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    if (ef) fin_exp++;
    if (fin_r) fin_cnt++;
    chk("red_col", col_r, mc);
    chk("red_fil", fil_r, mr);
    chk("red_hs",  hs_r, (mc < 2) ? 0 : 1);
    chk("red_vs",  vs_r, (mr < 1) ? 0 : 1);
    chk("red_vid", vid_r,
        (mc >= 3 && mc < 7 && mr >= 2 && mr < 5) ? 1 : 0);
    chk("red_fin", fin_r, ef);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_col", col_d, 0);
    chk("rst_fil", fil_d, 0);
    chk("rst_hs",  hs_d, 0);
    chk("rst_vs",  vs_d, 0);
    chk("rst_vid", vid_d, 0);
    chk("rst_fin", fin_d, 0);
    chk("rst_hs_pol", hs_p, 1);
    chk("rst_vs_pol", vs_p, 1);
    rst = 1'b0;

    run_to(127);
    chk("col127", col_d, 127);
    chk("hs127", hs_d, 0);
    chk("hs127_pol", hs_p, 1);
    run_to(128);
    chk("hs128", hs_d, 1);
    chk("hs128_pol", hs_p, 0);
    chk("vs_row0", vs_d, 0);
    chk("vid_row0", vid_d, 0);

    run_to(500);
    chk("col500", col_d, 500);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_col", col_d, 0);
    chk("mid_rst_fil", fil_d, 0);
    chk("mid_rst_hs",  hs_d, 0);
    chk("mid_rst_vs",  vs_d, 0);
    chk("mid_rst_vid", vid_d, 0);
    chk("mid_rst_fin", fin_d, 0);
    @(negedge clk);
    rst = 1'b0;
    pos = 0;
    @(negedge clk);
    chk("idle_col", col_d, 0);
    run_to(1);
    chk("rel_col", col_d, 1);
    chk("rel_fil", fil_d, 0);

    for (int i = 0; i < 6; i++) begin
      ce_d = i[0] ? 1'b0 : 1'b1;
      @(negedge clk);
      if (ce_d) pos++;
      chk("gate_col", col_d, pos);
    end
    ce_d = 1'b0;

    run_to(1055);
    chk("col1055", col_d, 1055);
    chk("fil_pre_wrap", fil_d, 0);
    run_to(1056);
    chk("wrap_col", col_d, 0);
    chk("wrap_fil", fil_d, 1);
    chk("wrap_fin", fin_d, 0);
    chk("vs_row1", vs_d, 0);
    run_to(2 * 1056);
    chk("vs_row2", vs_d, 1);
    chk("row2_hs", hs_d, 0);

    run_to(34 * 1056 + 216);
    chk("vid_r34", vid_d, 0);
    run_to(35 * 1056 + 215);
    chk("vid_215", vid_d, 0);
    run_to(35 * 1056 + 216);
    chk("vid_216", vid_d, 1);
    chk("fil35", fil_d, 35);
    run_to(35 * 1056 + 1015);
    chk("vid_1015", vid_d, 1);
    run_to(35 * 1056 + 1016);
    chk("vid_1016", vid_d, 0);

    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("red_rst_col", col_r, 0);
    chk("red_rst_hs", hs_r, 0);
    rst = 1'b0;
    mc = 0;
    mr = 0;

    for (int i = 0; i < 48; i++) red_step(1'b1);
    chk("frame_col", col_r, 0);
    chk("frame_fil", fil_r, 0);
    chk("frame_fin_cnt", fin_cnt, 1);

    for (int i = 0; i < 192; i++) red_step(i[0]);
    chk("gated_fin_cnt", fin_cnt, 3);

    for (int i = 0; i < 400; i++)
      red_step(logic'($urandom_range(0, 1)));
    chk("rand_fin_cnt", fin_cnt, fin_exp);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
